// File: rtl/axil_pkg.sv
// Shared AXI4-Lite constants and elaboration helpers for the register file.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Ceiling log2, usable in localparam expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/s_axil_regfile_wr.sv
// AXI4-Lite write-side join: latches AW and W independently, issues a single
// commit pulse once both are held and no response is pending, then owns B.
module s_axil_regfile_wr
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IDXW       = 6
) (
  input  logic                    axi_clock,
  input  logic                    rst,
  input  logic [IDXW-1:0]         aw_idx,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic                    bvalid,
  input  logic                    bready,
  output logic                    commit,
  output logic [IDXW-1:0]         commit_idx,
  output logic [DATA_WIDTH-1:0]   commit_data,
  output logic [DATA_WIDTH/8-1:0] commit_strb
);

  logic                    aw_full;
  logic                    w_full;
  logic [IDXW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH/8-1:0] strb_q;

  // A latched channel stays closed until its response is taken.
  assign awready = !aw_full;
  assign wready  = !w_full;

  // Commit fires once per write: bvalid rising blocks a second fire.
  assign commit      = aw_full && w_full && !bvalid;
  assign commit_idx  = idx_q;
  assign commit_data = data_q;
  assign commit_strb = strb_q;

  // Channel latches and response valid; B handshake reopens both channels.
  always_ff @(posedge axi_clock) begin
    if (rst) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      bvalid  <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else if (bvalid && bready) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      bvalid  <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        aw_full <= 1'b1;
        idx_q   <= aw_idx;
      end
      if (wvalid && wready) begin
        w_full <= 1'b1;
        data_q <= wdata;
        strb_q <= wstrb;
      end
      if (commit) bvalid <= 1'b1;
    end
  end

endmodule

// File: rtl/s_axil_regfile.sv
// AXI4-Lite register file: RW control registers (optionally self-clearing)
// followed by RO status registers, with write/read strobes to user logic.
module s_axil_regfile
  import axil_pkg::*;
#(
  parameter int                          DATA_WIDTH  = 32,
  parameter int                          ADDR_WIDTH  = 8,
  parameter int                          N_CTRL      = 8,
  parameter int                          N_STAT      = 8,
  parameter logic [N_CTRL-1:0]           PULSE_MASK  = '0,
  parameter logic [N_CTRL*DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           axi_clock,
  input  logic                           rst,
  output logic [N_CTRL*DATA_WIDTH-1:0]   ctrl_out,
  output logic [N_CTRL-1:0]              ctrl_wr_stb,
  input  logic [N_STAT*DATA_WIDTH-1:0]   stat_in,
  output logic [N_STAT-1:0]              stat_rd_stb,
  input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr,
  input  logic [2:0]                     s_axil_awprot,
  input  logic                           s_axil_awvalid,
  output logic                           s_axil_awready,
  input  logic [DATA_WIDTH-1:0]          s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axil_wstrb,
  input  logic                           s_axil_wvalid,
  output logic                           s_axil_wready,
  output logic [1:0]                     s_axil_bresp,
  output logic                           s_axil_bvalid,
  input  logic                           s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axil_araddr,
  input  logic [2:0]                     s_axil_arprot,
  input  logic                           s_axil_arvalid,
  output logic                           s_axil_arready,
  output logic [DATA_WIDTH-1:0]          s_axil_rdata,
  output logic [1:0]                     s_axil_rresp,
  output logic                           s_axil_rvalid,
  input  logic                           s_axil_rready
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int LSB  = clog2(NB);
  localparam int IDXW = ADDR_WIDTH - LSB;

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("s_axil_regfile: DATA_WIDTH must be 32 or 64");
  end
  if (N_CTRL + N_STAT > (1 << IDXW)) begin : g_bad_map
    $error("s_axil_regfile: N_CTRL+N_STAT exceeds address space");
  end

  logic [N_CTRL-1:0][DATA_WIDTH-1:0] ctrl_q;
  logic [N_STAT-1:0][DATA_WIDTH-1:0] stat_w;
  logic                              commit;
  logic                              commit_ctrl;
  logic [IDXW-1:0]                   commit_idx;
  logic [DATA_WIDTH-1:0]             commit_data;
  logic [NB-1:0]                     commit_strb;
  logic [IDXW-1:0]                   ar_idx;
  logic                              ar_hs;
  logic [DATA_WIDTH-1:0]             rd_word;
  logic                              rd_err;
  logic [N_STAT-1:0]                 rd_stb_nxt;
  logic                              unused_ok;

  assign ctrl_out    = ctrl_q;
  assign stat_w      = stat_in;
  assign commit_ctrl = 32'(commit_idx) < N_CTRL;
  assign ar_idx      = s_axil_araddr[ADDR_WIDTH-1:LSB];
  assign ar_hs       = s_axil_arvalid && s_axil_arready;
  // One read in flight: the channel reopens only after R is taken.
  assign s_axil_arready = !s_axil_rvalid;
  // Protection bits and sub-word address bits carry no meaning here.
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot,
                       s_axil_awaddr[LSB-1:0], s_axil_araddr[LSB-1:0]};

  s_axil_regfile_wr #(
    .DATA_WIDTH(DATA_WIDTH),
    .IDXW      (IDXW)
  ) u_wr (
    .axi_clock  (axi_clock),
    .rst        (rst),
    .aw_idx     (s_axil_awaddr[ADDR_WIDTH-1:LSB]),
    .awvalid    (s_axil_awvalid),
    .awready    (s_axil_awready),
    .wdata      (s_axil_wdata),
    .wstrb      (s_axil_wstrb),
    .wvalid     (s_axil_wvalid),
    .wready     (s_axil_wready),
    .bvalid     (s_axil_bvalid),
    .bready     (s_axil_bready),
    .commit     (commit),
    .commit_idx (commit_idx),
    .commit_data(commit_data),
    .commit_strb(commit_strb)
  );

  // Control registers: byte-lane merge at commit; pulse registers hold a
  // written value for one cycle, then fall back to their reset value.
  always_ff @(posedge axi_clock) begin
    if (rst) begin
      ctrl_q <= RESET_VALUE;
    end else begin
      for (int k = 0; k < N_CTRL; k++) begin
        if (commit && 32'(commit_idx) == k) begin
          for (int b = 0; b < NB; b++) begin
            if (commit_strb[b]) ctrl_q[k][b*8 +: 8] <= commit_data[b*8 +: 8];
          end
        end else if (PULSE_MASK[k]) begin
          ctrl_q[k] <= RESET_VALUE[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Write response code and one-cycle write strobe, both set at commit.
  always_ff @(posedge axi_clock) begin
    if (rst) begin
      ctrl_wr_stb  <= '0;
      s_axil_bresp <= RESP_OKAY;
    end else begin
      ctrl_wr_stb <= '0;
      if (commit) begin
        s_axil_bresp <= commit_ctrl ? RESP_OKAY : RESP_SLVERR;
        for (int k = 0; k < N_CTRL; k++) begin
          if (32'(commit_idx) == k) ctrl_wr_stb[k] <= 1'b1;
        end
      end
    end
  end

  // Read decode: ctrl, then status, anything else is an error reading zero.
  always_comb begin
    rd_word    = '0;
    rd_err     = 1'b1;
    rd_stb_nxt = '0;
    for (int k = 0; k < N_CTRL; k++) begin
      if (32'(ar_idx) == k) begin
        rd_word = ctrl_q[k];
        rd_err  = 1'b0;
      end
    end
    for (int j = 0; j < N_STAT; j++) begin
      if (32'(ar_idx) == N_CTRL + j) begin
        rd_word       = stat_w[j];
        rd_err        = 1'b0;
        rd_stb_nxt[j] = 1'b1;
      end
    end
  end

  // Read response register: captured at AR handshake, held until R taken.
  always_ff @(posedge axi_clock) begin
    if (rst) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
      s_axil_rresp  <= RESP_OKAY;
      stat_rd_stb   <= '0;
    end else begin
      stat_rd_stb <= '0;
      if (ar_hs) begin
        s_axil_rvalid <= 1'b1;
        s_axil_rdata  <= rd_word;
        s_axil_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        stat_rd_stb   <= rd_stb_nxt;
      end else if (s_axil_rvalid && s_axil_rready) begin
        s_axil_rvalid <= 1'b0;
      end
    end
  end

endmodule
